score_keeper: RTL
=================

SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-003 SHALL have port game_en, input, 1, level; high while a round is running.
REQ-004 SHALL have port game_over, input, 1, level; high when a collision has ended the round.
REQ-005 SHALL have port score_get, input, 1, level from the obstacle manager; may stay high for several consecutive cycles per obstacle passed.
REQ-006 SHALL have port clear_hi, input, 1, synchronous request to zero the high score.
REQ-007 SHALL have port score_bcd, output, 12, current score as three BCD digits [11:8]=hundreds, [7:4]=tens, [3:0]=ones.
REQ-008 SHALL have port hi_bcd, output, 12, high score in the same BCD layout.
REQ-009 SHALL have port score_inc, output, 1, one-cycle pulse in the cycle score_bcd changes by +1.
REQ-010 SHALL have port new_record, output, 1, level; high in OVER when the finished round beat the old high score.
REQ-011 SHALL have port state, output, 2, FSM state: 00=IDLE, 01=PLAY, 10=OVER.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, PLAY, OVER; encoding 11 is unreachable and SHALL return to IDLE on the next clock.
REQ-013 IDLE->PLAY SHALL occur when game_en=1 and game_over=0; on that edge score_bcd SHALL clear to 000 and new_record SHALL clear to 0.
REQ-014 PLAY->OVER SHALL occur when game_over=1; PLAY->IDLE SHALL occur when game_en=0 and game_over=0, with the score held and the high score unchanged.
REQ-015 OVER->IDLE SHALL occur when game_en=0; OVER SHALL hold while game_en=1.
REQ-016 A registered copy of score_get SHALL be kept; a scoring event is score_get=1 with the registered copy 0 (rising edge).
REQ-017 Only one increment SHALL occur per rising edge, however long score_get stays high.
REQ-018 Scoring events SHALL be counted only in PLAY; in IDLE and OVER they SHALL be ignored, but the edge register SHALL still track score_get.
REQ-019 A scoring event sampled at edge N SHALL appear in score_bcd, with score_inc=1, after edge N (latency 1 clock).
REQ-020 Increment SHALL be decimal: ones 9->0 carries into tens; tens 9->0 carries into hundreds; no digit SHALL ever hold A-F.
REQ-021 Score SHALL saturate at 999; an event at 999 SHALL leave score_bcd=999 and score_inc=0.
REQ-022 If game_over=1 and a scoring event occur in the same PLAY cycle, the event SHALL be counted before the high-score compare.
REQ-023 On the PLAY->OVER transition, if the final score (including any same-cycle event) > hi_bcd as unsigned 12-bit, hi_bcd SHALL take the final score and new_record SHALL be set to 1; equal SHALL NOT count as a record.
REQ-024 clear_hi SHALL zero hi_bcd only in IDLE; in PLAY and OVER it SHALL be ignored.
REQ-025 All outputs SHALL be driven directly from registers, with no combinational path from input to output.

Reset
REQ-026 On reset assertion, without waiting for clk: state=IDLE, score_bcd=000, hi_bcd=000, score_inc=0, new_record=0, score_get edge register=0.
REQ-027 Reset asserted mid-round SHALL discard the current score without updating hi_bcd.
REQ-028 After reset deasserts, the first rising edge SHALL evaluate transitions normally.

Verification
REQ-029 Reset, then game_en=1, then score_get held high for 5 cycles -> score_bcd=001; exactly one score_inc pulse.
REQ-030 In PLAY from 009, one score_get edge -> score_bcd=010; from 099 -> 100; from 999 -> stays 999 with no score_inc.
REQ-031 With hi=012, score reaches 015, then game_over=1 -> state=OVER, hi_bcd=015, new_record=1; repeat with score=015 and hi=015 -> hi unchanged, new_record=0.
REQ-032 Score=007 and hi=007, with a score_get edge and game_over=1 in the same cycle -> score_bcd=008, hi_bcd=008, new_record=1.
REQ-033 score_get edges in IDLE and in OVER -> score_bcd unchanged; clear_hi in OVER -> hi unchanged; clear_hi in IDLE -> hi_bcd=000.
REQ-034 Reset pulsed asynchronously between clk edges during PLAY with score=042 -> all outputs at reset values immediately; hi_bcd=000.

Source files
------------

// File: rtl/score_keeper.sv
// Round score keeper: 3-digit BCD score with a saturating increment, high-score tracking and a record flag.
// Latency 1 clk from a score_get rising edge to score_bcd/score_inc; all outputs are registered; no backpressure.
module score_keeper (
   input  logic        clk,
   input  logic        reset,
   input  logic        game_en,
   input  logic        game_over,
   input  logic        score_get,
   input  logic        clear_hi,
   output logic [11:0] score_bcd,
   output logic [11:0] hi_bcd,
   output logic        score_inc,
   output logic        new_record,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      PLAY = 2'b01,
      OVER = 2'b10,
      BAD  = 2'b11
   } state_t;

   state_t      cur_state, nxt_state;
   logic        get_q;
   logic        score_evt;
   logic        score_max;
   logic [11:0] score_plus;
   logic [11:0] score_nxt;
   logic [11:0] hi_nxt;
   logic        inc_nxt;
   logic        rec_nxt;

   assign score_evt = score_get & ~get_q;
   assign score_max = (score_bcd == 12'h999);
   assign state     = cur_state;

   // Decimal +1 with ripple carry across digits; the 999 case is excluded by score_max.
   always_comb begin
      score_plus = score_bcd;
      if (score_bcd[3:0] == 4'd9) begin
         score_plus[3:0] = 4'd0;
         if (score_bcd[7:4] == 4'd9) begin
            score_plus[7:4]  = 4'd0;
            score_plus[11:8] = score_bcd[11:8] + 4'd1;
         end else begin
            score_plus[7:4] = score_bcd[7:4] + 4'd1;
         end
      end else begin
         score_plus[3:0] = score_bcd[3:0] + 4'd1;
      end
   end

   always_comb begin
      nxt_state = cur_state;
      score_nxt = score_bcd;
      hi_nxt    = hi_bcd;
      inc_nxt   = 1'b0;
      rec_nxt   = new_record;
      case (cur_state)
         IDLE: begin
            if (clear_hi) hi_nxt = 12'h000;
            if (game_en && !game_over) begin
               nxt_state = PLAY;
               score_nxt = 12'h000;
               rec_nxt   = 1'b0;
            end
         end
         PLAY: begin
            if (score_evt && !score_max) begin
               score_nxt = score_plus;
               inc_nxt   = 1'b1;
            end
            // The compare uses score_nxt so a same-cycle scoring event is included.
            if (game_over) begin
               nxt_state = OVER;
               if (score_nxt > hi_bcd) begin
                  hi_nxt  = score_nxt;
                  rec_nxt = 1'b1;
               end
            end else if (!game_en) begin
               nxt_state = IDLE;
            end
         end
         OVER: begin
            if (!game_en) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state  <= IDLE;
         score_bcd  <= 12'h000;
         hi_bcd     <= 12'h000;
         score_inc  <= 1'b0;
         new_record <= 1'b0;
         get_q      <= 1'b0;
      end else begin
         cur_state  <= nxt_state;
         score_bcd  <= score_nxt;
         hi_bcd     <= hi_nxt;
         score_inc  <= inc_nxt;
         new_record <= rec_nxt;
         get_q      <= score_get;
      end
   end

endmodule
